// File: rtl/program_loader.sv
// program_loader: holds the CPU in reset while a byte stream is assembled into
// 16-bit instruction words and written into the ICache, then releases the CPU.
// Stream format: count byte (0 means 256 words), then two bytes per word, high byte first.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        cpu_reset,
  output logic [7:0]  write_instruction_index,
  output logic [15:0] write_instruction,
  output logic [8:0]  word_count,
  output logic        busy,
  output logic        error
);

  localparam int unsigned REL_MIN = (RELEASE_CYCLES < 1) ? 1 : RELEASE_CYCLES;
  localparam int unsigned REL_W   = $clog2(REL_MIN + 1);
  localparam int unsigned IDLE_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_WAIT_COUNT = 3'd0,
    S_WAIT_B0    = 3'd1,
    S_WAIT_B1    = 3'd2,
    S_RELEASE    = 3'd3,
    S_RUN        = 3'd4,
    S_ERROR      = 3'd5
`ifdef LOADER_CHECKSUM_EN
    , S_CHECK    = 3'd6
`endif
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [8:0]          target;
  logic [7:0]          ptr;
  logic [7:0]          b0;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [REL_W-1:0]    rel_cnt;
  logic                xfer;
  logic                timed;
  logic                idle_hit;
  logic                last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_acc;
`endif

  // Handshake and timeout qualifiers shared by next-state and datapath logic
  always_comb begin
    xfer      = rx_valid & rx_ready;
    timed     = (state == S_WAIT_B0) || (state == S_WAIT_B1)
`ifdef LOADER_CHECKSUM_EN
                || (state == S_CHECK)
`endif
                ;
    idle_hit  = (TIMEOUT_CYCLES != 0) && timed && !xfer &&
                (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
    last_word = ((word_count + 9'd1) == target);
  end

  // Next-state decode; load_req overrides everything, including a same-cycle byte
  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT_COUNT: if (xfer) state_nxt = S_WAIT_B0;
      S_WAIT_B0: begin
        if (xfer)          state_nxt = S_WAIT_B1;
        else if (idle_hit) state_nxt = S_ERROR;
      end
      S_WAIT_B1: begin
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          state_nxt = last_word ? S_CHECK : S_WAIT_B0;
`else
          state_nxt = last_word ? S_RELEASE : S_WAIT_B0;
`endif
        end else if (idle_hit) begin
          state_nxt = S_ERROR;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (xfer)          state_nxt = (rx_data == xor_acc) ? S_RELEASE : S_ERROR;
        else if (idle_hit) state_nxt = S_ERROR;
      end
`endif
      S_RELEASE: if (rel_cnt == REL_W'(REL_MIN)) state_nxt = S_RUN;
      S_RUN:     state_nxt = S_RUN;
      S_ERROR:   state_nxt = S_ERROR;
      default:   state_nxt = S_WAIT_COUNT;
    endcase
    if (load_req) state_nxt = S_WAIT_COUNT;
  end

  // State, registered status outputs, counters and word assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                   <= S_WAIT_COUNT;
      rx_ready                <= 1'b1;
      cpu_reset               <= 1'b1;
      busy                    <= 1'b1;
      error                   <= 1'b0;
      write_instruction_index <= 8'd0;
      write_instruction       <= 16'd0;
      word_count              <= 9'd0;
      target                  <= 9'd0;
      ptr                     <= 8'd0;
      b0                      <= 8'd0;
      idle_cnt                <= '0;
      rel_cnt                 <= '0;
`ifdef LOADER_CHECKSUM_EN
      xor_acc                 <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      rx_ready  <= (state_nxt == S_WAIT_COUNT) || (state_nxt == S_WAIT_B0) ||
                   (state_nxt == S_WAIT_B1)
`ifdef LOADER_CHECKSUM_EN
                   || (state_nxt == S_CHECK)
`endif
                   ;
      cpu_reset <= (state_nxt != S_RUN);
      busy      <= (state_nxt != S_RUN);
      error     <= (state_nxt == S_ERROR);

      if (load_req || xfer || !timed) idle_cnt <= '0;
      else                            idle_cnt <= idle_cnt + IDLE_W'(1);

      if (!load_req && (state == S_RELEASE)) rel_cnt <= rel_cnt + REL_W'(1);
      else                                   rel_cnt <= '0;

      if (load_req) begin
        ptr        <= 8'd0;
        target     <= 9'd0;
        word_count <= 9'd0;
`ifdef LOADER_CHECKSUM_EN
        xor_acc    <= 8'd0;
`endif
      end else if (xfer) begin
        case (state)
          S_WAIT_COUNT: begin
            target     <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            word_count <= 9'd0;
            ptr        <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_acc    <= 8'd0;
`endif
          end
          S_WAIT_B0: begin
            b0      <= rx_data;
`ifdef LOADER_CHECKSUM_EN
            xor_acc <= xor_acc ^ rx_data;
`endif
          end
          S_WAIT_B1: begin
            write_instruction       <= {b0, rx_data};
            write_instruction_index <= ptr;
            ptr                     <= ptr + 8'd1;
            if (word_count != 9'd256) word_count <= word_count + 9'd1;
`ifdef LOADER_CHECKSUM_EN
            xor_acc                 <= xor_acc ^ rx_data;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
